// File: rtl/jxli_fpmul_serial_if.sv
`default_nettype none
// ============================================================================
// Module   : jxli_fpmul_serial_if
// Purpose  : Beat-serial operand bus and parallel result bus for jxli_fpmul_serial
// Revision : 1.0  initial release
// ============================================================================
interface jxli_fpmul_serial_if #(
  parameter int DW = 4,
  parameter int FW = 8
);
  logic          enable;
  logic [DW-1:0] data;
  logic [FW-1:0] result;
  logic          valid;
  logic          busy;

  modport master (output enable, output data, input result, input valid, input busy);
  modport slave  (input enable, input data, output result, output valid, output busy);
endinterface
`default_nettype wire

// File: rtl/jxli_fpmul_serial.sv
`default_nettype none
// ============================================================================
// Module   : jxli_fpmul_serial
// Purpose  : Beat-serial minifloat multiplier, 3-cycle datapath, RNE rounding.
//            Define JXLI_FPMUL_SUBNORMAL_EN for gradual underflow (else FTZ/DAZ).
// Revision : 1.0  initial release
// ============================================================================
module jxli_fpmul_serial #(
  parameter int EW = 4,
  parameter int MW = 3,
  parameter int DW = 4
) (
  input  logic               clock,
  input  logic               reset,
  jxli_fpmul_serial_if.slave bus
);
  localparam int FW    = 1 + EW + MW;
  localparam int BEATS = FW / DW;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BIAS  = 2**(EW-1) - 1;
  localparam int PW    = 2*MW + 2;
  localparam int LW    = $clog2(PW);
  localparam int EXW   = EW + 3;

  localparam logic signed [EXW-1:0] BIAS_S  = EXW'(BIAS);
  localparam logic signed [EXW-1:0] TWO_MW  = EXW'(2*MW);
  localparam logic signed [EXW-1:0] ONE_S   = EXW'(1);
  localparam logic signed [EXW-1:0] EXP_INF = EXW'(2**EW - 1);
  localparam logic        [EXW-1:0] SH_MAX  = EXW'(MW + 2);

  typedef enum logic [2:0] {
    S_LOAD_A = 3'd0,
    S_LOAD_B = 3'd1,
    S_CALC1  = 3'd2,
    S_CALC2  = 3'd3,
    S_CALC3  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [FW-1:0]          a_q, a_d, b_q, b_d;
  logic                   sign_q, sign_d, nan_q, nan_d, inf_q, inf_d, zero_q, zero_d;
  logic [MW:0]            ma_q, ma_d, mb_q, mb_d;
  logic [EW-1:0]          ea_q, ea_d, eb_q, eb_d;
  logic [PW-1:0]          p_q, p_d;
  logic signed [EXW-1:0]  e_q, e_d;
  logic [FW-1:0]          result_q, result_d;
  logic                   valid_q, valid_d;

  logic [EW-1:0]          xa, xb;
  logic [MW-1:0]          fa, fb;
  logic                   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, last_beat;
  logic [LW-1:0]          lz;
  logic [PW-1:0]          pn;
  logic signed [EXW-1:0]  er, exp_o;
  logic [EXW-1:0]         sh;
  logic [2*PW-1:0]        wide;
  logic [MW:0]            mant;
  logic [MW+1:0]          mant_r;
  logic                   guard, sticky, rup, uflow;
  logic [FW-1:0]          res;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_LOAD_A;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      nan_q    <= 1'b0;
      inf_q    <= 1'b0;
      zero_q   <= 1'b0;
      ma_q     <= '0;
      mb_q     <= '0;
      ea_q     <= '0;
      eb_q     <= '0;
      p_q      <= '0;
      e_q      <= '0;
      result_q <= '1;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      nan_q    <= nan_d;
      inf_q    <= inf_d;
      zero_q   <= zero_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      ea_q     <= ea_d;
      eb_q     <= eb_d;
      p_q      <= p_d;
      e_q      <= e_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    nan_d    = nan_q;
    inf_d    = inf_q;
    zero_d   = zero_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    ea_d     = ea_q;
    eb_d     = eb_q;
    p_d      = p_q;
    e_d      = e_q;
    result_d = result_q;
    valid_d  = valid_q;

    last_beat = (cnt_q == CW'(BEATS-1));
    xa = a_q[FW-2 -: EW];
    xb = b_q[FW-2 -: EW];
    fa = a_q[MW-1:0];
    fb = b_q[MW-1:0];
    a_nan = (&xa) & (|fa);
    b_nan = (&xb) & (|fb);
    a_inf = (&xa) & ~(|fa);
    b_inf = (&xb) & ~(|fb);

    // Normalise the product so its leading one sits at the top bit
    lz = '0;
    for (int i = 0; i < PW; i++) begin
      if (p_q[i]) lz = LW'(i);
    end
    pn = p_q << (LW'(PW-1) - lz);
    er = e_q + $signed({{(EXW-LW){1'b0}}, lz}) - TWO_MW;

`ifdef JXLI_FPMUL_SUBNORMAL_EN
    a_zero = (xa == '0) && (fa == '0);
    b_zero = (xb == '0) && (fb == '0);
    sh     = '0;
    if (er < ONE_S) begin
      sh = ONE_S - er;
      if (sh > SH_MAX) sh = SH_MAX;
    end
    uflow  = 1'b0;
`else
    a_zero = (xa == '0);
    b_zero = (xb == '0);
    sh     = '0;
    uflow  = 1'b0;
`endif

    // Right shift denormalises tiny results; shifted-out bits feed sticky
    wide   = {pn, {PW{1'b0}}} >> sh;
    mant   = wide[2*PW-1 -: MW+1];
    guard  = wide[2*PW-2-MW];
    sticky = |wide[2*PW-3-MW:0];
    rup    = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + {{(MW+1){1'b0}}, rup};
    if (sh == '0) exp_o = er + $signed({{(EXW-1){1'b0}}, mant_r[MW+1]});
    else          exp_o = $signed({{(EXW-1){1'b0}}, mant_r[MW]});
`ifndef JXLI_FPMUL_SUBNORMAL_EN
    uflow = (exp_o < ONE_S);
`endif

    if (nan_q)                 res = {sign_q, {EW{1'b1}}, {MW{1'b1}}};
    else if (inf_q)            res = {sign_q, {EW{1'b1}}, {MW{1'b0}}};
    else if (zero_q)           res = {sign_q, {(FW-1){1'b0}}};
    else if (exp_o >= EXP_INF) res = {sign_q, {EW{1'b1}}, {MW{1'b0}}};
    else if (uflow)            res = {sign_q, {(FW-1){1'b0}}};
    else                       res = {sign_q, exp_o[EW-1:0], mant_r[MW-1:0]};

    case (state_q)
      S_LOAD_A, S_DONE: begin
        if (bus.enable) begin
          a_d     = FW'({a_q, bus.data});
          valid_d = 1'b0;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_LOAD_B;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = S_LOAD_A;
          end
        end
      end
      S_LOAD_B: begin
        if (bus.enable) begin
          b_d = FW'({b_q, bus.data});
          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_CALC1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_CALC1: begin
        sign_d  = a_q[FW-1] ^ b_q[FW-1];
        nan_d   = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        inf_d   = a_inf | b_inf;
        zero_d  = a_zero | b_zero;
        ma_d    = {xa != '0, fa};
        mb_d    = {xb != '0, fb};
        ea_d    = (xa == '0) ? EW'(1) : xa;
        eb_d    = (xb == '0) ? EW'(1) : xb;
        state_d = S_CALC2;
      end
      S_CALC2: begin
        p_d     = PW'(ma_q) * PW'(mb_q);
        e_d     = $signed({3'b000, ea_q}) + $signed({3'b000, eb_q}) - BIAS_S;
        state_d = S_CALC3;
      end
      S_CALC3: begin
        result_d = res;
        valid_d  = 1'b1;
        state_d  = S_DONE;
      end
      default: state_d = S_LOAD_A;
    endcase
  end

  assign bus.result = result_q;
  assign bus.valid  = valid_q;
  assign bus.busy   = (state_q == S_CALC1) || (state_q == S_CALC2) || (state_q == S_CALC3);

endmodule
`default_nettype wire

// File: tb/tb_jxli_fpmul_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_jxli_fpmul_serial
// Purpose  : Scoreboard bench for jxli_fpmul_serial (E4M3, two beats/operand)
// Revision : 1.0  initial release
// ============================================================================
module tb_jxli_fpmul_serial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
  } exp_t;
  exp_t sb[$];

  jxli_fpmul_serial_if #(.DW(4), .FW(8)) bus();
  jxli_fpmul_serial #(.EW(4), .MW(3), .DW(4)) dut (.clock(clk), .reset(rst), .bus(bus));

  always #5 clk = ~clk;

`ifdef JXLI_FPMUL_SUBNORMAL_EN
  localparam logic [7:0] R_SUB1 = 8'h01;
  localparam logic [7:0] R_SUBR = 8'h08;
  localparam logic [7:0] R_TINY = 8'h04;
`else
  localparam logic [7:0] R_SUB1 = 8'h00;
  localparam logic [7:0] R_SUBR = 8'h00;
  localparam logic [7:0] R_TINY = 8'h00;
`endif

  // {A, B, expected product}
  localparam int NV = 20;
  logic [23:0] vec [NV] = '{
    {8'h39, 8'h39, 8'h3A}, {8'hB8, 8'h40, 8'hC0}, {8'h78, 8'h00, 8'h7F},
    {8'h78, 8'hC0, 8'hF8}, {8'h79, 8'h38, 8'h7F}, {8'h77, 8'h77, 8'h78},
    {8'h01, 8'h38, R_SUB1}, {8'h08, 8'h08, 8'h00}, {8'h38, 8'h38, 8'h38},
    {8'h39, 8'h3B, 8'h3C}, {8'h3B, 8'h3B, 8'h3F}, {8'h3D, 8'h3D, 8'h43},
    {8'h3A, 8'h3A, 8'h3C}, {8'h3A, 8'h3E, 8'h41}, {8'h39, 8'h3E, 8'h40},
    {8'h71, 8'h3E, 8'h78}, {8'h07, 8'h39, R_SUBR}, {8'h08, 8'h30, R_TINY},
    {8'h80, 8'h38, 8'h80}, {8'h08, 8'h38, 8'h08}
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive_beat(input logic [3:0] d);
    bus.enable = 1'b1;
    bus.data   = d;
    @(posedge clk); #1;
    bus.enable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("valid_timeout", {31'd0, bus.valid}, 32'd1);
  endtask

  task automatic load_op(input logic [7:0] a, input logic [7:0] b, input int gap);
    drive_beat(a[7:4]); idle(gap);
    drive_beat(a[3:0]); idle(gap);
    drive_beat(b[7:4]); idle(gap);
    drive_beat(b[3:0]);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] r, input int gap);
    sb.push_back('{a, b, r});
    load_op(a, b, gap);
    wait_valid();
  endtask

  // Monitor: every rising valid retires one scoreboard entry
  logic vprev = 1'b0;
  always @(negedge clk) begin
    if (bus.valid && !vprev) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=%0h required=none at %0t", bus.result, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("result_%02h_x_%02h", e.a, e.b), {24'd0, bus.result}, {24'd0, e.r});
      end
    end
    vprev = bus.valid;
  end

  initial begin
    bus.enable = 1'b0;
    bus.data   = '0;
    rst        = 1'b1;
    idle(3);
    chk("reset_result", {24'd0, bus.result}, 32'hFF);
    chk("reset_valid", {31'd0, bus.valid}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    idle(1);

    // 1.5 * 1.5 with cycle-exact latency and busy window
    sb.push_back('{8'h3C, 8'h3C, 8'h41});
    load_op(8'h3C, 8'h3C, 0);
    for (int i = 0; i < 3; i++) begin
      chk("busy_in_calc", {31'd0, bus.busy}, 32'd1);
      chk("valid_in_calc", {31'd0, bus.valid}, 32'd0);
      idle(1);
    end
    chk("latency_valid", {31'd0, bus.valid}, 32'd1);
    chk("busy_after_calc", {31'd0, bus.busy}, 32'd0);

    for (int i = 0; i < NV; i++) begin
      logic [23:0] v;
      v = vec[i];
      run_op(v[23:16], v[15:8], v[7:0], 0);
    end

    run_op(8'h3C, 8'h3C, 8'h41, 5);

    // enable held high through CALC1..CALC3 must be ignored
    sb.push_back('{8'hB8, 8'hB8, 8'h38});
    load_op(8'hB8, 8'hB8, 0);
    bus.enable = 1'b1;
    bus.data   = 4'hF;
    idle(3);
    bus.enable = 1'b0;
    chk("calc_enable_ignored", {31'd0, bus.valid}, 32'd1);
    idle(2);

    // first A beat in DONE drops valid on that edge
    chk("done_valid_pre", {31'd0, bus.valid}, 32'd1);
    sb.push_back('{8'h38, 8'hC0, 8'hC0});
    drive_beat(4'h3);
    chk("done_drop_valid", {31'd0, bus.valid}, 32'd0);
    drive_beat(4'h8);
    drive_beat(4'hC);
    drive_beat(4'h0);
    wait_valid();

    // reset after one B beat discards the partial operands
    drive_beat(4'h3); drive_beat(4'hC); drive_beat(4'h4);
    rst = 1'b1;
    idle(1);
    chk("rst_loadb_result", {24'd0, bus.result}, 32'hFF);
    chk("rst_loadb_valid", {31'd0, bus.valid}, 32'd0);
    rst = 1'b0;
    run_op(8'h38, 8'h38, 8'h38, 0);

    // reset while in CALC2 aborts the product
    load_op(8'h3C, 8'h3C, 0);
    idle(1);
    rst = 1'b1;
    idle(1);
    chk("rst_calc2_result", {24'd0, bus.result}, 32'hFF);
    chk("rst_calc2_valid", {31'd0, bus.valid}, 32'd0);
    chk("rst_calc2_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    idle(6);
    chk("abort_no_valid", {31'd0, bus.valid}, 32'd0);
    run_op(8'h38, 8'h38, 8'h38, 0);

    idle(2);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
